conv_window_gen_3x3: RTL and testbench
======================================

# conv_window_gen_3x3

Streaming 3x3 sliding-window generator: accepts a raster-order pixel stream, one 32-bit word per valid cycle, and presents the nine taps of each complete 3x3 neighbourhood together with a one-cycle valid strobe. It is the producer side of the convolution path. Its nine window outputs and valid strobe wire directly to the data inputs and valid input of the 3x3 convolution core. Valid-only window positions are used: no padding.

## Interface
- DATA_WIDTH, 32, pixel word width (FP32, treated as opaque bits)
- IMG_WIDTH, 28, pixels per row; must be ≥ 3
- IMG_HEIGHT, 28, rows per frame; must be ≥ 3
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Pixel_In  in  DATA_WIDTH  pixel word, raster order (row-major, left to right)
- Pixel_Valid  in  1  Pixel_In is accepted on this rising edge
- Window_Out0..Window_Out8  out  DATA_WIDTH each  taps, row-major: 0 = top-left, 2 = top-right, 4 = centre, 8 = bottom-right
- Window_Valid  out  1  taps hold a complete window this cycle
- Frame_Done  out  1  one-cycle pulse coincident with the last window of a frame

## Operation
- Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) track the position of the next pixel to be accepted.
- On accept, col increments.
  - At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At the last pixel of the frame, both wrap to 0, so the next frame starts immediately.
- Two line buffers of depth IMG_WIDTH shift on accept only.
  - Line buffer 1 input is Pixel_In; its output is the pixel one row above.
  - Line buffer 2 input is line buffer 1's output; its output is the pixel two rows above.
- Window register: 3x3 array, updated on accept only.
  - Each column shifts one place left.
  - The new right column is {lb2_out, lb1_out, Pixel_In}, top to bottom.
- Window_Valid is registered.
  - Set to 1 on an accept where row ≥ 2 and col ≥ 2 (before the counters increment).
  - Otherwise 0, including every cycle with Pixel_Valid = 0.
- Frame_Done is registered: set to 1 on the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1), otherwise 0.
- Idle cycles (Pixel_Valid = 0):
  - Counters, line buffers and window register hold.
  - Window_Out keeps the last window; consumers gate on Window_Valid.
- Across frames, line-buffer contents are not cleared. Stale data is never exposed, because rows 0–1 of a frame never assert Window_Valid.
- There is no backpressure. The consumer must accept a window in every cycle Window_Valid is high.

## Timing
- Reset (rst low, asynchronous): counters, line buffers, window register, Window_Out0..8, Window_Valid and Frame_Done all go to 0.
- Reset mid-frame: partial frame is discarded. The first pixel after release is pixel (0,0).
- Latency: the window for centre (r-1, c-1) appears one cycle after accepting pixel (r, c).
- Its taps are pixels rows r-2..r by cols c-2..c.
- Each frame produces (IMG_WIDTH-2)·(IMG_HEIGHT-2) windows.
- Continuous input gives a burst of IMG_WIDTH-2 consecutive valid cycles per row from row 2 onward.
- Frame_Done and the last Window_Valid are asserted in the same cycle.
- Back-to-back frames need no idle cycles.

## Configuration
- CONV_WIN_STRIDE2_EN, when defined: Window_Valid is additionally gated by (row − 2) even and (col − 2) even, giving stride-2 output.
  - Window count is ⌈(IMG_WIDTH-2)/2⌉·⌈(IMG_HEIGHT-2)/2⌉.
  - Frame_Done still pulses on the last pixel of the frame; it coincides with a Window_Valid pulse only when that position qualifies.
- When not defined: stride 1, every position with row ≥ 2 and col ≥ 2 is valid.

## Structure
- Shared package conv_pkg holds:
  - DATA_WIDTH default
  - KERNEL_DIM = 3
  - tap index constants TAP_TL..TAP_BR (0..8), shared with the convolution core
- Sub-module conv_line_buffer: parameterised depth and width, enable-gated shift register, async active-low reset to 0. Instantiated twice.
- Counters, window register and output registers live in the top module.

## Test plan
All tests use IMG_WIDTH = IMG_HEIGHT = 5 and Pixel_In = 5·r + c, unless stated otherwise.
- Continuous frame, pixels 0..24 → 9 windows.
  - First window one cycle after pixel 12: taps {0,1,2,5,6,7,10,11,12}.
  - Last window: taps {12,13,14,17,18,19,22,23,24}, with Frame_Done = 1.
- Pixel_Valid alternating 1/0 → the same 9 windows in the same order, each a single-cycle pulse.
  - Window_Valid = 0 in every gap cycle.
  - Window_Out holds during gaps.
- Two frames back-to-back, second frame offset by +100 → second frame's first window is {100,101,102,105,106,107,110,111,112}.
  - No Window_Valid during the second frame's rows 0–1.
- Assert rst after pixel 13 → all outputs read 0 while rst is low.
  - A restarted frame gives its first window after pixel 12, with taps {0,1,2,5,6,7,10,11,12}.
- CONV_WIN_STRIDE2_EN defined → exactly 4 windows, centred (1,1), (1,3), (3,1), (3,3).
  - Centre taps are 6, 8, 16, 18.
  - Frame_Done coincides with the (3,3) window.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution path: default word width, kernel size and the
// row-major tap indices used by both the window generator and the convolution core.
package conv_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned KERNEL_DIM         = 3;
  localparam int unsigned NUM_TAPS           = KERNEL_DIM * KERNEL_DIM;

  localparam int unsigned TAP_TL = 0;
  localparam int unsigned TAP_TM = 1;
  localparam int unsigned TAP_TR = 2;
  localparam int unsigned TAP_ML = 3;
  localparam int unsigned TAP_MM = 4;
  localparam int unsigned TAP_MR = 5;
  localparam int unsigned TAP_BL = 6;
  localparam int unsigned TAP_BM = 7;
  localparam int unsigned TAP_BR = 8;

endpackage

// File: rtl/conv_window_gen_3x3_if.sv
// Pixel-stream in / 3x3-window out bundle of the window generator. The master is the pixel
// source (and window consumer); the slave is the window generator itself.
interface conv_window_gen_3x3_if
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] Pixel_In;
  logic                  Pixel_Valid;
  logic [DATA_WIDTH-1:0] Window_Out0;
  logic [DATA_WIDTH-1:0] Window_Out1;
  logic [DATA_WIDTH-1:0] Window_Out2;
  logic [DATA_WIDTH-1:0] Window_Out3;
  logic [DATA_WIDTH-1:0] Window_Out4;
  logic [DATA_WIDTH-1:0] Window_Out5;
  logic [DATA_WIDTH-1:0] Window_Out6;
  logic [DATA_WIDTH-1:0] Window_Out7;
  logic [DATA_WIDTH-1:0] Window_Out8;
  logic                  Window_Valid;
  logic                  Frame_Done;

  modport master (
    output Pixel_In, Pixel_Valid,
    input  Window_Out0, Window_Out1, Window_Out2, Window_Out3, Window_Out4,
    input  Window_Out5, Window_Out6, Window_Out7, Window_Out8,
    input  Window_Valid, Frame_Done
  );

  modport slave (
    input  Pixel_In, Pixel_Valid,
    output Window_Out0, Window_Out1, Window_Out2, Window_Out3, Window_Out4,
    output Window_Out5, Window_Out6, Window_Out7, Window_Out8,
    output Window_Valid, Frame_Done
  );

endinterface

// File: rtl/conv_line_buffer.sv
// Enable-gated shift register of DEPTH words; dout is the word written DEPTH shifts ago.
module conv_line_buffer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (en) begin
      mem_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen_3x3.sv
// Streaming 3x3 sliding-window generator (valid positions only, no padding).
// Define CONV_WIN_STRIDE2_EN to emit only even-offset windows (stride 2).
module conv_window_gen_3x3
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_gen_3x3_if.slave bus
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);

  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [DATA_WIDTH-1:0] win_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0] win_d [NUM_TAPS];
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] lb1_out, lb2_out;
  logic                  accept, col_last, row_last, win_pos;

  assign accept   = bus.Pixel_Valid;
  assign col_last = (col_q == ColW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RowW'(IMG_HEIGHT - 1));

`ifdef CONV_WIN_STRIDE2_EN
  // (row-2) and (col-2) even is the same as row and col even.
  assign win_pos = (row_q >= RowW'(2)) && (col_q >= ColW'(2)) && !row_q[0] && !col_q[0];
`else
  assign win_pos = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
`endif

  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (bus.Pixel_In),
    .dout (lb1_out)
  );

  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NUM_TAPS); k++) begin
      win_d[k] = win_q[k];
    end
    if (accept) begin
      for (int r = 0; r < int'(KERNEL_DIM); r++) begin
        for (int c = 0; c < int'(KERNEL_DIM) - 1; c++) begin
          win_d[r*KERNEL_DIM + c] = win_q[r*KERNEL_DIM + c + 1];
        end
      end
      win_d[TAP_TR] = lb2_out;
      win_d[TAP_MR] = lb1_out;
      win_d[TAP_BR] = bus.Pixel_In;
    end
  end

  assign valid_d = accept && win_pos;
  assign done_d  = accept && col_last && row_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < int'(NUM_TAPS); k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      for (int k = 0; k < int'(NUM_TAPS); k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  assign bus.Window_Out0  = win_q[TAP_TL];
  assign bus.Window_Out1  = win_q[TAP_TM];
  assign bus.Window_Out2  = win_q[TAP_TR];
  assign bus.Window_Out3  = win_q[TAP_ML];
  assign bus.Window_Out4  = win_q[TAP_MM];
  assign bus.Window_Out5  = win_q[TAP_MR];
  assign bus.Window_Out6  = win_q[TAP_BL];
  assign bus.Window_Out7  = win_q[TAP_BM];
  assign bus.Window_Out8  = win_q[TAP_BR];
  assign bus.Window_Valid = valid_q;
  assign bus.Frame_Done   = done_q;

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Directed bench for conv_window_gen_3x3 on a 5x5 frame with Pixel_In = base + 5*r + c.
module tb_conv_window_gen_3x3;
  import conv_pkg::*;

  localparam int unsigned DW = 32;
  localparam int          W  = 5;
  localparam int          H  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_window_gen_3x3_if #(.DATA_WIDTH(DW)) bus ();

  conv_window_gen_3x3 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] taps [9];
  always_comb begin
    taps[0] = bus.Window_Out0;
    taps[1] = bus.Window_Out1;
    taps[2] = bus.Window_Out2;
    taps[3] = bus.Window_Out3;
    taps[4] = bus.Window_Out4;
    taps[5] = bus.Window_Out5;
    taps[6] = bus.Window_Out6;
    taps[7] = bus.Window_Out7;
    taps[8] = bus.Window_Out8;
  end

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] first_win [9];
  logic [DW-1:0] last_win  [9];
  logic [DW-1:0] centres [$];

  logic [DW-1:0] exp_first0   [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  logic [DW-1:0] exp_last0    [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
  logic [DW-1:0] exp_first100 [9] = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
  logic [DW-1:0] exp_centres  [4] = '{6, 8, 16, 18};

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    bus.Pixel_Valid = v;
    bus.Pixel_In    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, DW'(bus.Window_Valid), '0);
    check({tag, "_done"}, DW'(bus.Frame_Done), '0);
    for (int k = 0; k < 9; k++) check($sformatf("%s_tap%0d", tag, k), taps[k], '0);
  endtask

  // Feeds one full frame; optional idle cycle after every pixel.
  task automatic send_frame(input int base, input bit gaps, output int nwin);
    logic [DW-1:0] held [9];
    bit ev;
    bit have;
    nwin = 0;
    have = 1'b0;
    centres.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(1'b1, DW'(base + W * r + c));
        ev = (r >= 2) && (c >= 2);
`ifdef CONV_WIN_STRIDE2_EN
        ev = ev && (r % 2 == 0) && (c % 2 == 0);
`endif
        check($sformatf("valid r%0d c%0d", r, c), DW'(bus.Window_Valid), DW'(ev));
        check($sformatf("done r%0d c%0d", r, c), DW'(bus.Frame_Done),
              DW'((r == H - 1) && (c == W - 1)));
        if (ev) begin
          nwin++;
          for (int k = 0; k < 9; k++) begin
            held[k] = DW'(base + W * (r - 2 + k / 3) + (c - 2 + k % 3));
            check($sformatf("tap r%0d c%0d k%0d", r, c, k), taps[k], held[k]);
            if (nwin == 1) first_win[k] = taps[k];
            last_win[k] = taps[k];
          end
          centres.push_back(taps[4]);
        end
        have = ev;
        if (gaps) begin
          send(1'b0, 32'hdead_beef);
          check($sformatf("gap valid r%0d c%0d", r, c), DW'(bus.Window_Valid), '0);
          check($sformatf("gap done r%0d c%0d", r, c), DW'(bus.Frame_Done), '0);
          if (have) begin
            for (int k = 0; k < 9; k++)
              check($sformatf("gap hold r%0d c%0d k%0d", r, c, k), taps[k], held[k]);
          end
        end
      end
    end
  endtask

  initial begin
    int n;
    bus.Pixel_Valid = 1'b0;
    bus.Pixel_In    = '0;
    rst = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

`ifdef CONV_WIN_STRIDE2_EN
    send_frame(0, 1'b0, n);
    check("stride2 count", DW'(n), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("stride2 centre%0d", i),
            (i < centres.size()) ? centres[i] : '1, exp_centres[i]);
    send_frame(100, 1'b1, n);
    check("stride2 count gaps", DW'(n), 4);
`else
    send_frame(0, 1'b0, n);
    check("cont count", DW'(n), 9);
    for (int k = 0; k < 9; k++) check($sformatf("first win k%0d", k), first_win[k], exp_first0[k]);
    for (int k = 0; k < 9; k++) check($sformatf("last win k%0d", k), last_win[k], exp_last0[k]);

    send_frame(0, 1'b1, n);
    check("gap count", DW'(n), 9);
    for (int k = 0; k < 9; k++) check($sformatf("gap first k%0d", k), first_win[k], exp_first0[k]);

    send_frame(0, 1'b0, n);
    send_frame(100, 1'b0, n);
    check("b2b count", DW'(n), 9);
    for (int k = 0; k < 9; k++)
      check($sformatf("b2b first k%0d", k), first_win[k], exp_first100[k]);
`endif

    // Reset in the middle of a frame, just after pixel 13.
    for (int i = 0; i <= 13; i++) send(1'b1, DW'(i));
    @(negedge clk);
    bus.Pixel_Valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_zero("midrst async");
    @(posedge clk);
    #1;
    check_zero("midrst held");
    @(negedge clk);
    rst = 1'b1;
    send_frame(0, 1'b0, n);
`ifdef CONV_WIN_STRIDE2_EN
    check("restart count", DW'(n), 4);
`else
    check("restart count", DW'(n), 9);
`endif
    for (int k = 0; k < 9; k++)
      check($sformatf("restart first k%0d", k), first_win[k], exp_first0[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
